// File: rtl/board_line_clear.sv
// Line-clear engine for the Tetris board kept in processor RAM: scans bottom-up, drops full rows,
// compacts survivors downward and zero-fills the top. Shares the RAM port through a req/gnt mux.
module board_line_clear #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int BASE_ADDR  = 0,
    parameter int CELL_BITS  = 3,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            lines_cleared,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wEn,
    output logic [31:0]           mem_dataIn,
    input  logic [31:0]           mem_dataOut
);

    localparam int ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
    localparam logic signed [5:0] LastRow = 6'(ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StChkRd,
        StChkCap,
        StCopyRd,
        StCopyCap,
        StCopyWr,
        StFill,
        StFinish
    } state_t;

    state_t                 state;
    logic signed [5:0]      src;
    logic signed [5:0]      dst;
    logic [ColW-1:0]        col;
    logic                   full;
    logic [4:0]             count;
    logic [CELL_BITS-1:0]   wr_color;

    logic signed [5:0]      src_dec;
    logic signed [5:0]      dst_dec;
    logic [ColW-1:0]        col_inc;
    logic                   row_full;
    state_t                 adv_state;
    logic [ADDR_WIDTH-1:0]  adv_addr;
    logic                   unused_data;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic signed [5:0] row,
                                                        input logic [ColW-1:0] c);
        cell_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(COLS) * ADDR_WIDTH'($unsigned(row))
                  + ADDR_WIDTH'(c);
    endfunction

    assign src_dec     = src - 6'sd1;
    assign dst_dec     = dst - 6'sd1;
    assign col_inc     = col + ColW'(1);
    assign row_full    = full & (|mem_dataOut[CELL_BITS-1:0]);
    assign unused_data = ^mem_dataOut[31:CELL_BITS];

    assign mem_req    = busy;
    assign mem_wEn    = ((state == StCopyWr) || (state == StFill)) && mem_gnt;
    assign mem_dataIn = {{(32 - CELL_BITS){1'b0}}, wr_color};

    // Where to go after both pointers step past a surviving row.
    always_comb begin
        adv_state = StChkRd;
        adv_addr  = cell_addr(src_dec, '0);
        if (src_dec[5]) begin
            if (dst_dec[5]) begin
                adv_state = StFinish;
            end else begin
                adv_state = StFill;
                adv_addr  = cell_addr(dst_dec, '0);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StIdle;
            src           <= '0;
            dst           <= '0;
            col           <= '0;
            full          <= 1'b0;
            count         <= '0;
            wr_color      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            mem_addr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    // A start coinciding with the done pulse belongs to the finished pass.
                    if (start && !done) begin
                        src      <= LastRow;
                        dst      <= LastRow;
                        count    <= '0;
                        col      <= '0;
                        full     <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= cell_addr(LastRow, '0);
                        state    <= StChkRd;
                    end
                end
                StChkRd: begin
                    if (mem_gnt) state <= StChkCap;
                end
                StChkCap: begin
                    if (col != LastCol) begin
                        col      <= col_inc;
                        full     <= row_full;
                        mem_addr <= cell_addr(src, col_inc);
                        state    <= StChkRd;
                    end else begin
                        col  <= '0;
                        full <= 1'b1;
                        if (row_full) begin
                            count <= count + 5'd1;
                            src   <= src_dec;
                            if (src_dec[5]) begin
                                wr_color <= '0;
                                mem_addr <= cell_addr(dst, '0);
                                state    <= StFill;
                            end else begin
                                mem_addr <= cell_addr(src_dec, '0);
                                state    <= StChkRd;
                            end
                        end else if (src != dst) begin
                            mem_addr <= cell_addr(src, '0);
                            state    <= StCopyRd;
                        end else begin
                            src      <= src_dec;
                            dst      <= dst_dec;
                            wr_color <= '0;
                            mem_addr <= adv_addr;
                            state    <= adv_state;
                        end
                    end
                end
                StCopyRd: begin
                    if (mem_gnt) state <= StCopyCap;
                end
                StCopyCap: begin
                    wr_color <= mem_dataOut[CELL_BITS-1:0];
                    mem_addr <= cell_addr(dst, col);
                    state    <= StCopyWr;
                end
                StCopyWr: begin
                    if (mem_gnt) begin
                        if (col != LastCol) begin
                            col      <= col_inc;
                            mem_addr <= cell_addr(src, col_inc);
                            state    <= StCopyRd;
                        end else begin
                            col      <= '0;
                            src      <= src_dec;
                            dst      <= dst_dec;
                            wr_color <= '0;
                            mem_addr <= adv_addr;
                            state    <= adv_state;
                        end
                    end
                end
                StFill: begin
                    if (mem_gnt) begin
                        if (col != LastCol) begin
                            col      <= col_inc;
                            mem_addr <= cell_addr(dst, col_inc);
                        end else begin
                            col <= '0;
                            dst <= dst_dec;
                            if (dst_dec[5]) begin
                                state <= StFinish;
                            end else begin
                                mem_addr <= cell_addr(dst_dec, '0);
                            end
                        end
                    end
                end
                StFinish: begin
                    lines_cleared <= count;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_board_line_clear.sv
// Bench for board_line_clear: RAM model with grant mux, directed and random boards checked against
// a row-queue compaction model.
module tb_board_line_clear;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int Cells = COLS * ROWS;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic        mem_req;
    logic        mem_gnt;
    logic [11:0] mem_addr;
    logic        mem_wEn;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;

    logic [31:0] ram      [Cells];
    logic [31:0] init_img [Cells];
    logic [31:0] exp_img  [Cells];
    logic        load_req = 1'b0;
    int          ram_idx;
    int          exp_cnt;
    int          exp_wr;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_wr   = 0;
    int          n_viol = 0;
    bit          gnt_rand = 1'b0;

    board_line_clear dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .lines_cleared(lines_cleared),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_addr     (mem_addr),
        .mem_wEn      (mem_wEn),
        .mem_dataIn   (mem_dataIn),
        .mem_dataOut  (mem_dataOut)
    );

    always #5 clock = ~clock;

    assign ram_idx = int'(mem_addr);

    // RAM behind the port mux; without grant the other master owns the read data.
    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < Cells; i++) ram[i] <= init_img[i];
        end else if (mem_gnt) begin
            if (mem_wEn && ram_idx < Cells) ram[ram_idx] <= mem_dataIn;
            mem_dataOut <= (ram_idx < Cells) ? ram[ram_idx] : 32'h0;
        end else begin
            mem_dataOut <= $urandom;
        end
    end

    initial begin
        mem_gnt = 1'b1;
        forever begin
            @(negedge clock);
            mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (mem_wEn === 1'b1) begin
                if (mem_gnt) n_wr++;
                else n_viol++;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < Cells; i++) init_img[i] = 32'h0;
    endtask

    task automatic set_cell(input int r, input int c, input int v);
        init_img[r * COLS + c] = 32'(v);
    endtask

    task automatic fill_row(input int r);
        for (int c = 0; c < COLS; c++) set_cell(r, c, $urandom_range(1, 7));
    endtask

    task automatic partial_row(input int r);
        for (int c = 0; c < COLS; c++) set_cell(r, c, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7));
        set_cell(r, $urandom_range(0, COLS - 1), 0);
    endtask

    task automatic load_board();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Survivors keep their relative order and stack against the bottom; the rest becomes empty.
    task automatic model();
        int keep[$];
        logic [31:0] w;
        bit full;
        exp_cnt = 0;
        exp_wr  = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                w = ram[r * COLS + c];
                if (w[2:0] == 3'd0) full = 1'b0;
            end
            if (full) exp_cnt++;
            else keep.push_back(r);
        end
        for (int i = 0; i < Cells; i++) exp_img[i] = 32'h0;
        for (int k = 0; k < keep.size(); k++) begin
            for (int c = 0; c < COLS; c++) begin
                w = ram[keep[k] * COLS + c];
                exp_img[(ROWS - 1 - k) * COLS + c] = {29'h0, w[2:0]};
            end
            if (ROWS - 1 - k != keep[k]) exp_wr += COLS;
        end
        exp_wr += exp_cnt * COLS;
    endtask

    task automatic run_pass(input string tag, input bit rnd);
        int cyc;
        int wr0;
        int v0;
        int bad;
        int first_bad;
        model();
        wr0 = n_wr;
        v0  = n_viol;
        gnt_rand = rnd;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s/busy_after_start", tag), 32'(busy), 32'd1);
        check($sformatf("%s/req_eq_busy", tag), 32'(mem_req), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            tick();
            cyc++;
        end
        check($sformatf("%s/done_seen", tag), 32'(done), 32'd1);
        check($sformatf("%s/lines", tag), 32'(lines_cleared), 32'(exp_cnt));
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s/done_one_cycle", tag), 32'(done), 32'd0);
        check($sformatf("%s/start_at_done_ignored", tag), 32'(busy), 32'd0);
        gnt_rand = 1'b0;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < Cells; i++) begin
            if (ram[i] !== exp_img[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check($sformatf("%s/image_bad_cells(first=%0d)", tag, first_bad), 32'(bad), 32'd0);
        check($sformatf("%s/write_count", tag), 32'(n_wr - wr0), 32'(exp_wr));
        check($sformatf("%s/wen_without_gnt", tag), 32'(n_viol - v0), 32'd0);
    endtask

    initial begin
        logic [31:0] p_row [COLS];
        logic [31:0] q_row [COLS];
        int cyc;
        int wr0;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/lines", 32'(lines_cleared), 32'd0);
        check("rst/req", 32'(mem_req), 32'd0);
        check("rst/wen", 32'(mem_wEn), 32'd0);
        check("rst/addr", 32'(mem_addr), 32'd0);
        check("rst/din", mem_dataIn, 32'd0);
        reset = 1'b0;
        tick();

        clear_img();
        load_board();
        run_pass("empty", 1'b0);

        clear_img();
        fill_row(19);
        set_cell(18, 0, 3);
        load_board();
        run_pass("one_line", 1'b0);
        check("one_line/r19c0", ram[19 * COLS], 32'd3);

        clear_img();
        for (int r = 16; r < 20; r++) fill_row(r);
        set_cell(15, 4, 5);
        load_board();
        run_pass("four_lines", 1'b0);
        check("four_lines/r19c4", ram[19 * COLS + 4], 32'd5);

        // Interrupt the first compaction write with reset, then rerun on whatever is left.
        clear_img();
        fill_row(19);
        partial_row(18);
        partial_row(17);
        load_board();
        wr0 = n_wr;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (n_wr == wr0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("mid_copy/reached_write", 32'(n_wr > wr0), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_copy/busy", 32'(busy), 32'd0);
        check("mid_copy/wen", 32'(mem_wEn), 32'd0);
        check("mid_copy/lines", 32'(lines_cleared), 32'd0);
        reset = 1'b0;
        tick();
        run_pass("after_reset", 1'b0);

        clear_img();
        fill_row(19);
        fill_row(17);
        partial_row(18);
        partial_row(16);
        for (int c = 0; c < COLS; c++) begin
            p_row[c] = init_img[18 * COLS + c];
            q_row[c] = init_img[16 * COLS + c];
        end
        for (int pass = 0; pass < 2; pass++) begin
            load_board();
            run_pass(pass == 0 ? "pq" : "pq_gnt", pass == 1);
            check("pq/lines2", 32'(lines_cleared), 32'd2);
            for (int c = 0; c < COLS; c++) begin
                check($sformatf("pq/r19c%0d", c), ram[19 * COLS + c], p_row[c]);
                check($sformatf("pq/r18c%0d", c), ram[18 * COLS + c], q_row[c]);
            end
        end

        for (int t = 0; t < 6; t++) begin
            int top;
            clear_img();
            top = $urandom_range(0, 10);
            for (int r = top; r < ROWS; r++) begin
                if ($urandom_range(0, 9) < 3) fill_row(r);
                else partial_row(r);
            end
            load_board();
            run_pass($sformatf("rand%0d", t), (t % 2) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
